// File: rtl/m3_dequant_block_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m3_dequant_block_writer_if                                   |
// | Description : Coefficient stream (valid/ready) plus SRAM write bus of the  |
// |               dequantizer block writer.                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface m3_dequant_block_writer_if;
   logic        coef_valid;
   logic [15:0] coef_data;
   logic        coef_ready;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   // master: coefficient producer / SRAM observer; slave: the block writer
   modport master (output coef_valid, coef_data,
                   input  coef_ready, SRAM_address, SRAM_write_data, SRAM_we_n);
   modport slave  (input  coef_valid, coef_data,
                   output coef_ready, SRAM_address, SRAM_write_data, SRAM_we_n);
endinterface
`default_nettype wire

// File: rtl/m3_dequant_block_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m3_dequant_block_writer                                      |
// | Description : Dequantizes zig-zag 8x8 blocks of a Y,U,V frame and writes   |
// |               them row-major into the pre-IDCT SRAM segments.              |
// |               Macro M3_DEQUANT_SATURATE_EN: clamp instead of wrap.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module m3_dequant_block_writer #(
   parameter int Y_PRE_BASE = 76800,
   parameter int U_PRE_BASE = 153600,
   parameter int V_PRE_BASE = 192000,
   parameter int ROW_BLOCKS = 30
) (
   input  logic CLOCK_50_I,
   input  logic Resetn,
   input  logic M3_start,
   input  logic q_select,
   output logic M3_done,
   m3_dequant_block_writer_if.slave bus
);

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_Y     = 3'd1;
   localparam logic [2:0] c_ST_U     = 3'd2;
   localparam logic [2:0] c_ST_V     = 3'd3;
   localparam logic [2:0] c_ST_FLUSH = 3'd4;

   localparam logic [4:0] c_RB_LAST = 5'(ROW_BLOCKS - 1);

   // Raster position {ri,ci} of each zig-zag index; entry 0 sits in the LSBs
   localparam logic [383:0] c_ZZ_ROM = {
      6'd63, 6'd62, 6'd55, 6'd47, 6'd54, 6'd61, 6'd60, 6'd53,
      6'd46, 6'd39, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd58,
      6'd51, 6'd44, 6'd37, 6'd30, 6'd23, 6'd15, 6'd22, 6'd29,
      6'd36, 6'd43, 6'd50, 6'd57, 6'd56, 6'd49, 6'd42, 6'd35,
      6'd28, 6'd21, 6'd14, 6'd7,  6'd6,  6'd13, 6'd20, 6'd27,
      6'd34, 6'd41, 6'd48, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12,
      6'd5,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd24, 6'd17,
      6'd10, 6'd3,  6'd2,  6'd9,  6'd16, 6'd8,  6'd1,  6'd0};

   localparam logic [23:0] c_Q0_SHIFT = {3'd5, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd3};
   localparam logic [23:0] c_Q1_SHIFT = {3'd4, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd3};

   logic [2:0]  r_state;
   logic [5:0]  r_sc;
   logic [5:0]  r_cb;
   logic [4:0]  r_rb;
   logic        r_qsel;
   logic [17:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_we_n;
   logic        r_done;

   logic        w_busy, w_xfer, w_is_y;
   logic [8:0]  w_rom_idx;
   logic [5:0]  w_pos;
   logic [2:0]  w_ri, w_ci;
   logic [3:0]  w_diag;
   logic [2:0]  w_sidx;
   logic [4:0]  w_q_idx;
   logic [2:0]  w_shift;
   logic [15:0] w_deq;
   logic [17:0] w_row18, w_row_off, w_base, w_addr;
   logic [5:0]  w_c_end;
   logic        w_last_sc, w_last_cb, w_last_rb;
   logic [2:0]  w_next_plane;

   assign w_busy = (r_state == c_ST_Y) || (r_state == c_ST_U) || (r_state == c_ST_V);
   assign w_xfer = bus.coef_valid & w_busy;
   assign w_is_y = (r_state == c_ST_Y);

   assign w_rom_idx = {1'b0, r_sc, 2'b00} + {2'b00, r_sc, 1'b0};
   assign w_pos     = c_ZZ_ROM[w_rom_idx +: 6];
   assign w_ri      = w_pos[5:3];
   assign w_ci      = w_pos[2:0];

   assign w_diag  = {1'b0, w_ri} + {1'b0, w_ci};
   assign w_sidx  = w_diag[3] ? 3'd7 : w_diag[2:0];
   assign w_q_idx = {1'b0, w_sidx, 1'b0} + {2'b00, w_sidx};
   assign w_shift = r_qsel ? c_Q1_SHIFT[w_q_idx +: 3] : c_Q0_SHIFT[w_q_idx +: 3];

`ifdef M3_DEQUANT_SATURATE_EN
   logic [20:0] w_prod;
   logic        w_ovf;
   assign w_prod = {{5{bus.coef_data[15]}}, bus.coef_data} << w_shift;
   // Fits in 16 bits only while the six top bits all agree
   assign w_ovf  = ~((&w_prod[20:15]) | ~(|w_prod[20:15]));
   assign w_deq  = w_ovf ? (w_prod[20] ? 16'h8000 : 16'h7FFF) : w_prod[15:0];
`else
   assign w_deq  = bus.coef_data << w_shift;
`endif

   // Row stride 320 = 256+64 (Y) or 160 = 128+32 (U/V)
   assign w_row18   = {10'd0, r_rb, w_ri};
   assign w_row_off = w_is_y ? ((w_row18 << 8) + (w_row18 << 6))
                             : ((w_row18 << 7) + (w_row18 << 5));
   assign w_addr    = w_base + w_row_off + {9'd0, r_cb, w_ci};

   assign w_c_end   = w_is_y ? 6'd39 : 6'd19;
   assign w_last_sc = (r_sc == 6'd63);
   assign w_last_cb = (r_cb == w_c_end);
   assign w_last_rb = (r_rb == c_RB_LAST);

   always_comb begin
      w_base       = 18'(V_PRE_BASE);
      w_next_plane = c_ST_FLUSH;
      case (r_state)
         c_ST_Y: begin
            w_base       = 18'(Y_PRE_BASE);
            w_next_plane = c_ST_U;
         end
         c_ST_U: begin
            w_base       = 18'(U_PRE_BASE);
            w_next_plane = c_ST_V;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= c_ST_IDLE;
         r_sc    <= 6'd0;
         r_cb    <= 6'd0;
         r_rb    <= 5'd0;
         r_qsel  <= 1'b0;
         r_addr  <= 18'd0;
         r_wdata <= 16'd0;
         r_we_n  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= (r_state == c_ST_FLUSH);
         r_we_n <= ~w_xfer;
         if (w_xfer) begin
            r_addr  <= w_addr;
            r_wdata <= w_deq;
         end
         case (r_state)
            c_ST_IDLE: begin
               if (M3_start) begin
                  r_state <= c_ST_Y;
                  r_qsel  <= q_select;
                  r_sc    <= 6'd0;
                  r_cb    <= 6'd0;
                  r_rb    <= 5'd0;
               end
            end
            c_ST_Y, c_ST_U, c_ST_V: begin
               if (w_xfer) begin
                  r_sc <= r_sc + 6'd1;
                  if (w_last_sc) begin
                     if (w_last_cb) begin
                        r_cb <= 6'd0;
                        if (w_last_rb) begin
                           r_rb    <= 5'd0;
                           r_state <= w_next_plane;
                        end else begin
                           r_rb <= r_rb + 5'd1;
                        end
                     end else begin
                        r_cb <= r_cb + 6'd1;
                     end
                  end
               end
            end
            c_ST_FLUSH: r_state <= c_ST_IDLE;
            default:    r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign bus.coef_ready      = w_busy;
   assign bus.SRAM_address    = r_addr;
   assign bus.SRAM_write_data = r_wdata;
   assign bus.SRAM_we_n       = r_we_n;
   assign M3_done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_m3_dequant_block_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_m3_dequant_block_writer                                   |
// | Description : Random-stream bench for the dequant block writer with a      |
// |               frame-ordinal reference model (reduced plane height).        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_m3_dequant_block_writer;

   localparam int c_RB_N   = 2;
   localparam int c_Y_TOT  = 40 * c_RB_N * 64;
   localparam int c_UV_TOT = 20 * c_RB_N * 64;
   localparam int c_TOT    = c_Y_TOT + 2 * c_UV_TOT;

   logic clk = 1'b0;
   logic rstn;
   logic start;
   logic qsel;
   logic done;

   m3_dequant_block_writer_if bus ();

   m3_dequant_block_writer #(.ROW_BLOCKS(c_RB_N)) dut (
      .CLOCK_50_I (clk),
      .Resetn     (rstn),
      .M3_start   (start),
      .q_select   (qsel),
      .M3_done    (done),
      .bus        (bus)
   );

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int zz_r[64];
   int zz_c[64];
   int q0_sh[8] = '{3, 1, 2, 3, 3, 4, 4, 5};
   int q1_sh[8] = '{3, 0, 0, 1, 1, 2, 3, 4};

   bit          q_model;
   int          n_ord, n_wr, n_dup, done_cnt, cyc, last_wr_cyc;
   bit          seen[262144];
   bit          prev_xfer;
   logic [15:0] prev_data;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected write for the n-th coefficient accepted in a frame
   function automatic void model(input int n, input logic [15:0] d, input bit q,
                                 output logic [17:0] a, output logic [15:0] w);
      int k, cols, base, wid, blk, sc, rb, cb, ri, ci, s, sh, p;
      if (n < c_Y_TOT) begin
         k = n; cols = 40; base = 76800; wid = 320;
      end else if (n < c_Y_TOT + c_UV_TOT) begin
         k = n - c_Y_TOT; cols = 20; base = 153600; wid = 160;
      end else begin
         k = n - c_Y_TOT - c_UV_TOT; cols = 20; base = 192000; wid = 160;
      end
      blk = k / 64; sc = k % 64;
      rb = blk / cols; cb = blk % cols;
      ri = zz_r[sc]; ci = zz_c[sc];
      a  = 18'(base + (rb * 8 + ri) * wid + cb * 8 + ci);
      s  = (ri + ci > 7) ? 7 : ri + ci;
      sh = q ? q1_sh[s] : q0_sh[s];
      p  = int'($signed(d)) * (1 << sh);
`ifdef M3_DEQUANT_SATURATE_EN
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
`endif
      w = 16'(p);
   endfunction

   initial begin
      logic [17:0] ea;
      logic [15:0] ed;
      cyc = 0; last_wr_cyc = -10; prev_xfer = 1'b0; prev_data = 16'd0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rstn) begin
            n_ord = 0;
            prev_xfer = 1'b0;
         end else begin
            check_val("we_n", bus.SRAM_we_n, !prev_xfer);
            if (prev_xfer) begin
               model(n_ord, prev_data, q_model, ea, ed);
               check_val("addr", bus.SRAM_address, ea);
               check_val("data", bus.SRAM_write_data, ed);
               if (seen[bus.SRAM_address]) n_dup++;
               seen[bus.SRAM_address] = 1'b1;
               n_wr++;
               if (n_ord == c_Y_TOT) check_val("u_first", bus.SRAM_address, 153600);
               if (n_ord == c_Y_TOT + c_UV_TOT) check_val("v_first", bus.SRAM_address, 192000);
               if (n_ord == c_TOT - 1) begin
                  last_wr_cyc = cyc;
                  check_val("ready_last", bus.coef_ready, 0);
               end
               n_ord++;
            end
            if (done) begin
               done_cnt++;
               check_val("done_lat", cyc, last_wr_cyc + 1);
            end
            prev_xfer = bus.coef_valid & bus.coef_ready;
            prev_data = bus.coef_data;
         end
      end
   end

   // Returns one step after the edge that accepted d
   task automatic send_one(input logic [15:0] d, input bit pulse_start);
      int t;
      bus.coef_valid = 1'b0;
      if ($urandom_range(0, 99) == 0) repeat (20) @(posedge clk);
      while ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
      bus.coef_valid = 1'b1;
      bus.coef_data  = d;
      if (pulse_start) begin
         start = 1'b1;
         qsel  = 1'b1;
      end
      t = 0;
      while (!bus.coef_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 50) check_val("ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.coef_valid = 1'b0;
      start = 1'b0;
      qsel  = 1'b0;
   endtask

   task automatic new_frame(input bit q);
      q_model = q; n_ord = 0; n_wr = 0; n_dup = 0; done_cnt = 0;
      for (int i = 0; i < 262144; i++) seen[i] = 1'b0;
      qsel = q; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; qsel = 1'b0;
   endtask

   task automatic finish_frame();
      int t;
      bus.coef_valid = 1'b0;
      t = 0;
      while (done_cnt == 0 && t < 30) begin
         @(posedge clk); #1; t++;
      end
      repeat (5) @(posedge clk);
      #1;
      check_val("done_cnt", done_cnt, 1);
      check_val("writes", n_wr, c_TOT);
      check_val("dup_addr", n_dup, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ready"}, bus.coef_ready, 0);
      check_val({tag, "_we_n"}, bus.SRAM_we_n, 1);
      check_val({tag, "_addr"}, bus.SRAM_address, 0);
      check_val({tag, "_data"}, bus.SRAM_write_data, 0);
      check_val({tag, "_done"}, done, 0);
   endtask

   initial begin
      int idx;
      idx = 0;
      for (int d = 0; d < 15; d++) begin
         int lo, hi;
         lo = (d > 7) ? d - 7 : 0;
         hi = (d < 7) ? d : 7;
         if (d % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz_r[idx] = r; zz_c[idx] = d - r; idx++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz_r[idx] = r; zz_c[idx] = d - r; idx++; end
         end
      end

      rstn = 1'b0; start = 1'b0; qsel = 1'b0; q_model = 1'b0;
      bus.coef_valid = 1'b0; bus.coef_data = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rstn = 1'b1;
      @(posedge clk); #1;

      // Frame 1: Q0, directed first coefficients, stray start during Y
      new_frame(1'b0);
      send_one(16'd5, 1'b0);
      check_val("first_addr", bus.SRAM_address, 76800);
      check_val("first_data", bus.SRAM_write_data, 40);
      check_val("first_we_n", bus.SRAM_we_n, 0);
      for (int i = 1; i < 66; i++) send_one(16'($urandom), 1'b0);
      send_one(16'hFFFD, 1'b0);
      check_val("cb1_addr", bus.SRAM_address, 77128);
      check_val("cb1_data", bus.SRAM_write_data, 16'hFFFA);
      for (int i = 67; i < c_TOT; i++) send_one(16'($urandom), i == 500);
      finish_frame();

      // Frame 2: Q1, max coefficient at the last zig-zag slot, reset inside U
      new_frame(1'b1);
      for (int i = 0; i < 63; i++) send_one(16'($urandom), 1'b0);
      send_one(16'h7FFF, 1'b0);
      check_val("sat_addr", bus.SRAM_address, 79047);
`ifdef M3_DEQUANT_SATURATE_EN
      check_val("sat_data", bus.SRAM_write_data, 16'h7FFF);
`else
      check_val("sat_data", bus.SRAM_write_data, 16'hFFF0);
`endif
      for (int i = 64; i < c_Y_TOT + 100; i++) send_one(16'($urandom), 1'b0);
      @(negedge clk); #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Frame 3: restart after reset, full Q1 frame
      new_frame(1'b1);
      send_one(16'($urandom), 1'b0);
      check_val("restart_addr", bus.SRAM_address, 76800);
      for (int i = 1; i < c_TOT; i++) send_one(16'($urandom), 1'b0);
      finish_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
